// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection and global hold.
// Define ID_EX_STALL_CNT_EN to add the bubble_cnt_o / hold_cnt_o event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              valid_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  input  logic              MemToReg_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              MemWrite_o,
  output logic              MemRead_o,
  output logic              MemToReg_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       hold_cnt_o,
`endif
  output logic              valid_o,
  output logic              stall_o
);

  logic              valid_q, valid_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              alu_src_q, alu_src_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [9:0]        funct_q, funct_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              ctrl_en;

  // Load in EX whose rd is read by ID; rs2 is compared even for I-type (spurious stalls accepted).
  assign stall_o = !hold_i && valid_i && valid_q && mem_read_q && (rd_addr_q != '0) &&
                   ((rd_addr_q == RS1addr_i) || (rd_addr_q == RS2addr_i));

  assign ctrl_en = valid_i && !stall_o;

  always_comb begin
    valid_d      = valid_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    alu_op_d     = alu_op_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    funct_d      = funct_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    if (!hold_i) begin
      // Operands load even on a bubble; they are ignored while valid is low.
      rs1_data_d   = RS1data_i;
      rs2_data_d   = RS2data_i;
      imm_d        = Imm_i;
      funct_d      = funct_i;
      rs1_addr_d   = RS1addr_i;
      rs2_addr_d   = RS2addr_i;
      rd_addr_d    = RDaddr_i;
      valid_d      = ctrl_en;
      mem_write_d  = ctrl_en && MemWrite_i;
      mem_read_d   = ctrl_en && MemRead_i;
      mem_to_reg_d = ctrl_en && MemToReg_i;
      alu_src_d    = ctrl_en && ALUSrc_i;
      reg_write_d  = ctrl_en && RegWrite_i;
      alu_op_d     = ctrl_en ? ALUOp_i : 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= 2'b00;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, stall_o};
    hold_cnt_d   = hold_cnt_q + {31'd0, hold_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign hold_cnt_o   = hold_cnt_q;
`endif

  assign valid_o    = valid_q;
  assign MemWrite_o = mem_write_q;
  assign MemRead_o  = mem_read_q;
  assign MemToReg_o = mem_to_reg_q;
  assign ALUSrc_o   = alu_src_q;
  assign RegWrite_o = reg_write_q;
  assign ALUOp_o    = alu_op_q;
  assign RS1data_o  = rs1_data_q;
  assign RS2data_o  = rs2_data_q;
  assign Imm_o      = imm_q;
  assign funct_o    = funct_q;
  assign RS1addr_o  = rs1_addr_q;
  assign RS2addr_o  = rs2_addr_q;
  assign RDaddr_o   = rd_addr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/hold/flush/reset steps, then random traffic
// against a reference model of the pipeline-register rules. Honours ID_EX_STALL_CNT_EN.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          hold_i = 1'b0, valid_i = 1'b0;
  logic          MemWrite_i = 1'b0, MemRead_i = 1'b0, MemToReg_i = 1'b0, ALUSrc_i = 1'b0, RegWrite_i = 1'b0;
  logic [1:0]    ALUOp_i = '0;
  logic [DW-1:0] RS1data_i = '0, RS2data_i = '0, Imm_i = '0;
  logic [9:0]    funct_i = '0;
  logic [AW-1:0] RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;
  logic          MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o, valid_o, stall_o;
  logic [1:0]    ALUOp_o;
  logic [DW-1:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]    funct_o;
  logic [AW-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0]   bubble_cnt_o, hold_cnt_o;
`endif

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .valid_i(valid_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemToReg_i(MemToReg_i),
    .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .MemToReg_o(MemToReg_o),
    .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
`ifdef ID_EX_STALL_CNT_EN
    .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o),
`endif
    .valid_o(valid_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: the EX-stage instruction as seen by the bench.
  logic          m_valid, m_mw, m_mr, m_m2r, m_src, m_rw;
  logic [1:0]    m_op;
  logic [DW-1:0] m_rs1d, m_rs2d, m_imm;
  logic [9:0]    m_funct;
  logic [AW-1:0] m_rs1a, m_rs2a, m_rd;
  int unsigned   m_bubbles, m_holds;

  wire [128:0] dut_vec = {MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o, ALUOp_o,
                          RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o, valid_o};

  function automatic logic [128:0] model_vec();
    return {m_mw, m_mr, m_m2r, m_src, m_rw, m_op, m_rs1d, m_rs2d, m_imm, m_funct,
            m_rs1a, m_rs2a, m_rd, m_valid};
  endfunction

  // A load in EX whose destination (not x0) is read by a real, non-held ID instruction.
  function automatic logic model_hazard();
    return rst_i && !hold_i && valid_i && m_valid && m_mr && (m_rd != 0) &&
           (m_rd == RS1addr_i || m_rd == RS2addr_i);
  endfunction

  task automatic model_clear();
    {m_valid, m_mw, m_mr, m_m2r, m_src, m_rw, m_op} = '0;
    {m_rs1d, m_rs2d, m_imm, m_funct, m_rs1a, m_rs2a, m_rd} = '0;
    m_bubbles = 0;
    m_holds = 0;
  endtask

  task automatic model_edge();
    logic bubble;
    if (!rst_i) begin
      model_clear();
    end else if (hold_i) begin
      m_holds++;
    end else begin
      bubble = model_hazard();
      if (bubble) m_bubbles++;
      m_rs1d = RS1data_i; m_rs2d = RS2data_i; m_imm = Imm_i; m_funct = funct_i;
      m_rs1a = RS1addr_i; m_rs2a = RS2addr_i; m_rd = RDaddr_i;
      m_valid = valid_i && !bubble;
      if (m_valid) begin
        {m_mw, m_mr, m_m2r, m_src, m_rw, m_op} = {MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i, ALUOp_i};
      end else begin
        {m_mw, m_mr, m_m2r, m_src, m_rw, m_op} = '0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_counters();
`ifdef ID_EX_STALL_CNT_EN
    check("bubble_cnt", bubble_cnt_o, m_bubbles);
    check("hold_cnt", hold_cnt_o, m_holds);
`endif
  endtask

  // One clock: check combinational stall mid-cycle, advance model, check registered state after edge.
  task automatic cycle(input string tag);
    @(negedge clk_i);
    check({tag, ".stall"}, stall_o, model_hazard());
    model_edge();
    @(posedge clk_i);
    #1;
    check({tag, ".regs"}, dut_vec, model_vec());
    check_counters();
    $display("step %-12s hold=%0b valid_i=%0b stall=%0b valid_o=%0b rd_o=%0d mr_o=%0b",
             tag, hold_i, valid_i, stall_o, valid_o, RDaddr_o, MemRead_o);
  endtask

  task automatic present(input logic v, input logic mw, input logic mr, input logic m2r,
                         input logic src, input logic rw, input logic [1:0] op,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] rd);
    valid_i = v; MemWrite_i = mw; MemRead_i = mr; MemToReg_i = m2r; ALUSrc_i = src; RegWrite_i = rw;
    ALUOp_i = op; RS1data_i = d1; RS2data_i = d2; RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd;
    Imm_i = $urandom; funct_i = 10'($urandom);
  endtask

  task automatic rand_inputs();
    present($urandom_range(0, 99) < 85, 1'($urandom), $urandom_range(0, 99) < 40, 1'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    hold_i = $urandom_range(0, 99) < 10;
  endtask

  initial begin
    model_clear();
    // Reset held across 3 edges with busy inputs, including a would-be hazard pattern.
    present(1, 1, 1, 1, 1, 1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5, 5'd5, 5'd5);
    #1;
    for (int i = 0; i < 3; i++) cycle("reset");
    check("reset.valid_o", valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cycle("first_load");
    check("first_load.rd", RDaddr_o, 5'd5);

    // add x3,x1,x2
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3);
    cycle("add");
    check("add.fields", {RegWrite_o, ALUOp_o, RS1data_o, RS2data_o, RDaddr_o, valid_o},
          {1'b1, 2'b10, 32'd5, 32'd7, 5'd3, 1'b1});

    // Load-use: lw x5 then add x6,x5,x1 -> one bubble, then the add loads.
    m_bubbles = m_bubbles; // counters continue from reset
    present(1, 0, 1, 1, 1, 1, 2'b00, 32'd100, 32'd0, 5'd2, 5'd0, 5'd5);
    cycle("lw_x5");
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd9, 32'd4, 5'd5, 5'd1, 5'd6);
    #1;
    check("lu.stall_now", stall_o, 1'b1);
    cycle("lu_bubble");
    check("lu.bubble_ctrl", {valid_o, MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o, ALUOp_o}, 8'd0);
`ifdef ID_EX_STALL_CNT_EN
    check("lu.bubble_cnt1", bubble_cnt_o, 32'd1);
`endif
    cycle("lu_reload");
    check("lu.reload", {valid_o, RDaddr_o, RegWrite_o}, {1'b1, 5'd6, 1'b1});

    // No false hazards: lw x0 / read x0, and lw x5 / read x4,x6.
    present(1, 0, 1, 1, 1, 1, 2'b00, 32'd1, 32'd2, 5'd3, 5'd0, 5'd0);
    cycle("lw_x0");
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd1, 32'd2, 5'd0, 5'd0, 5'd7);
    cycle("read_x0");
    present(1, 0, 1, 1, 1, 1, 2'b00, 32'd1, 32'd2, 5'd3, 5'd0, 5'd5);
    cycle("lw_x5b");
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd1, 32'd2, 5'd4, 5'd6, 5'd7);
    cycle("read_x4x6");

    // Hold during a load-use: frozen for 2 edges, then exactly one bubble.
    present(1, 0, 1, 1, 1, 1, 2'b00, 32'd8, 32'd0, 5'd2, 5'd0, 5'd5);
    cycle("lw_x5c");
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd3, 32'd3, 5'd5, 5'd1, 5'd6);
    hold_i = 1'b1;
    cycle("hold1");
    cycle("hold2");
    check("hold.frozen", {valid_o, MemRead_o, RDaddr_o}, {1'b1, 1'b1, 5'd5});
    hold_i = 1'b0;
    cycle("hold_bubble");
    cycle("hold_reload");

    // Flushed slot: control bits must not leak through.
    present(0, 1, 1, 1, 1, 1, 2'b11, 32'd1, 32'd2, 5'd1, 5'd2, 5'd9);
    cycle("flush");
    check("flush.ctrl", {valid_o, RegWrite_o, MemWrite_o}, 3'b000);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle("random");
    end
    hold_i = 1'b0;

    // Reset asserted mid-stall: outputs and stall clear immediately.
    present(1, 0, 1, 1, 1, 1, 2'b00, 32'd8, 32'd0, 5'd2, 5'd0, 5'd5);
    cycle("lw_x5d");
    present(1, 0, 0, 0, 0, 1, 2'b10, 32'd3, 32'd3, 5'd5, 5'd1, 5'd6);
    #2;
    rst_i = 1'b0;
    #1;
    model_clear();
    check("midreset.regs", dut_vec, model_vec());
    check("midreset.stall", stall_o, 1'b0);
    check_counters();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cycle("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core, directly downstream of the decode control unit.
- Captures decode control bits, register operands, immediate, funct fields and register addresses at each clock edge, and presents them to EX.
- Contains the load-use hazard detector: requests a stall of PC and IF/ID, and injects a bubble into EX.
- Also honours a global hold (e.g. memory wait).

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- hold_i  in  1  global stall; freeze all EX-stage state
- valid_i  in  1  ID holds a real instruction (0 after IF/ID flush)
- MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i  in  1 each  decode control bits
- ALUOp_i  in  2  decode ALU op class
- RS1data_i, RS2data_i, Imm_i  in  DATA_W each  ID operands and sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW each  ID register addresses
- MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALU op class
- RS1data_o, RS2data_o, Imm_o  out  DATA_W each  registered operands
- funct_o  out  10  registered funct
- RS1addr_o, RS2addr_o, RDaddr_o  out  REG_AW each  registered addresses (used by forwarding)
- valid_o  out  1  EX holds a real instruction
- stall_o  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_i=0, asynchronous): every registered output is 0, including valid_o. While in reset, stall_o=0. Deassertion is sampled synchronously; the first capture occurs at the first rising edge with rst_i=1.
- stall_o is asserted when all of the following hold: hold_i=0, valid_i=1, valid_o=1, MemRead_o=1, RDaddr_o!=0, and (RDaddr_o==RS1addr_i or RDaddr_o==RS2addr_i).
- The RS2 comparison applies to all opcodes. Spurious stalls on I-type instructions are accepted; no opcode decode is done here.
- Per-edge update priority:
  1. hold_i=1: all registers keep their values. stall_o=0, since hold already freezes the front end.
  2. stall_o=1: bubble. valid_o, MemWrite_o, MemRead_o, MemToReg_o, RegWrite_o, ALUSrc_o go to 0 and ALUOp_o to 2'b00. Data/address/funct registers take their inputs; they are don't-care with valid_o=0, but loading them keeps the mux small.
  3. Otherwise: load all inputs. valid_o=valid_i.
- Whenever valid_i=0 is loaded, all control outputs are forced to 0 regardless of the *_i values. valid_o=0 therefore always implies no RegWrite, MemWrite or MemRead.
- Latency is one cycle from ID inputs to EX outputs. stall_o has zero latency and is combinational from inputs and current state.
- A load-use hazard produces exactly one bubble. The next cycle has valid_o=0, so stall_o drops and the re-presented instruction is loaded.
- Back-to-back loads to the same rd: each dependent consumer stalls once, relative to the load immediately ahead of it.
- hold_i asserted during the stall cycle: hold wins, no bubble is inserted that cycle, and the hazard is re-evaluated when hold_i falls.
- Reset mid-stall: outputs clear immediately and stall_o goes to 0.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined, adds:
  - output bubble_cnt_o [31:0]: count of bubbles inserted (edges taken via priority 2).
  - output hold_cnt_o [31:0]: count of edges with hold_i=1.
  - Both reset to 0 asynchronously and wrap from 0xFFFFFFFF to 0.
- When undefined, neither port exists and no counter logic is built.
- Core pipeline behaviour is identical either way.

Test Plan:
- Reset: drive all *_i nonzero with rst_i=0 across 3 edges → every output 0 and stall_o=0. Release rst_i → next edge loads inputs.
- Plain pass-through: ID presents add x3,x1,x2 (RegWrite=1, ALUOp=10, RS1data=5, RS2data=7) → after 1 edge: RegWrite_o=1, ALUOp_o=10, RS1data_o=5, RS2data_o=7, RDaddr_o=3, valid_o=1.
- Load-use: EX holds lw x5 (MemRead_o=1, RDaddr_o=5); ID presents add x6,x5,x1 → stall_o=1. Next edge: valid_o=0 and all control bits 0. Following edge: the add is loaded with stall_o=0. Exactly one bubble.
- No false hazard: lw x0 in EX with ID reading x0 → stall_o=0. lw x5 in EX with ID reading x4,x6 → stall_o=0.
- Hold precedence: during the load-use case above, assert hold_i for 2 cycles → outputs frozen and stall_o=0. On hold release → stall_o=1 and one bubble follows.
- Flushed slot: valid_i=0 with RegWrite_i=1, MemWrite_i=1 → valid_o=0, RegWrite_o=0, MemWrite_o=0. With ID_EX_STALL_CNT_EN defined, after the load-use test, bubble_cnt_o=1.
